// File: rtl/uart_rx.sv
// 8N1 UART receiver: recovers bytes from an idle-high serial line using a 3-bit
// clocks-per-bit select, with a one-cycle done strobe and stop-bit framing check.
`timescale 1ns/1ps
module uart_rx (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] baud_rate_select,
  input  logic       Rx_Serial,
  output logic [7:0] Rx_Byte,
  output logic       Rx_Done,
  output logic       Rx_Active,
  output logic       Framing_Error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  function automatic logic [10:0] bit_clocks(input logic [2:0] sel);
    logic [10:0] b;
    case (sel)
      3'd0:    b = 11'd1042;
      3'd1:    b = 11'd695;
      3'd2:    b = 11'd521;
      3'd3:    b = 11'd261;
      3'd4:    b = 11'd174;
      3'd5:    b = 11'd87;
      3'd6:    b = 11'd79;
      default: b = 11'd39;
    endcase
    return b;
  endfunction

  state_t      state, state_next;
  logic [10:0] clk_count, count_next;
  logic [2:0]  bit_index, index_next;
  logic [7:0]  shift, shift_next;
  logic [10:0] bit_len, bit_len_next;
  logic [7:0]  byte_next;
  logic        done_next, active_next, ferr_next;
  logic        rx_meta_p0, rx_s;
  logic [10:0] half_len;

  assign half_len = {1'b0, bit_len[10:1]};

  // Stage p0 -> rx_s: two-flop synchronizer on the asynchronous line
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_meta_p0 <= Rx_Serial;
      rx_s       <= rx_meta_p0;
    end
  end

  always_comb begin
    state_next   = state;
    count_next   = clk_count + 11'd1;
    index_next   = bit_index;
    shift_next   = shift;
    bit_len_next = bit_len;
    byte_next    = Rx_Byte;
    done_next    = 1'b0;
    ferr_next    = 1'b0;
    active_next  = Rx_Active;
    case (state)
      IDLE: begin
        count_next = 11'd0;
        index_next = 3'd0;
        if (!rx_s) begin
          state_next   = START;
          bit_len_next = bit_clocks(baud_rate_select);
          active_next  = 1'b1;
        end
      end
      START: begin
        // Half a bit in: a start bit that is no longer low was only a glitch
        if (clk_count == half_len - 11'd1) begin
          count_next = 11'd0;
          if (!rx_s) begin
            state_next = DATA;
          end else begin
            state_next  = IDLE;
            active_next = 1'b0;
          end
        end
      end
      DATA: begin
        if (clk_count == bit_len - 11'd1) begin
          count_next            = 11'd0;
          shift_next[bit_index] = rx_s;
          if (bit_index == 3'd7) begin
            state_next = STOP;
            index_next = 3'd0;
          end else begin
            index_next = bit_index + 3'd1;
          end
        end
      end
      STOP: begin
        if (clk_count == bit_len - 11'd1) begin
          count_next = 11'd0;
          state_next = CLEANUP;
          if (rx_s) begin
            byte_next = shift;
            done_next = 1'b1;
          end else begin
            ferr_next = 1'b1;
          end
        end
      end
      CLEANUP: begin
        // Hold here while the line stays low so a break is not seen as a new start
        count_next = 11'd0;
        if (rx_s) begin
          state_next  = IDLE;
          active_next = 1'b0;
        end
      end
      default: begin
        state_next  = IDLE;
        count_next  = 11'd0;
        index_next  = 3'd0;
        active_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      clk_count     <= 11'd0;
      bit_index     <= 3'd0;
      shift         <= 8'h00;
      bit_len       <= 11'd0;
      Rx_Byte       <= 8'h00;
      Rx_Done       <= 1'b0;
      Rx_Active     <= 1'b0;
      Framing_Error <= 1'b0;
    end else begin
      state         <= state_next;
      clk_count     <= count_next;
      bit_index     <= index_next;
      shift         <= shift_next;
      bit_len       <= bit_len_next;
      Rx_Byte       <= byte_next;
      Rx_Done       <= done_next;
      Rx_Active     <= active_next;
      Framing_Error <= ferr_next;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives 8N1 frames and checks outputs every cycle against a
// queue of expected done/framing events derived from the baud table and latency rule.
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] baud_rate_select = 3'd5;
  logic       Rx_Serial = 1'b1;
  logic [7:0] Rx_Byte;
  logic       Rx_Done;
  logic       Rx_Active;
  logic       Framing_Error;

  uart_rx dut (
    .clock(clock),
    .reset(reset),
    .baud_rate_select(baud_rate_select),
    .Rx_Serial(Rx_Serial),
    .Rx_Byte(Rx_Byte),
    .Rx_Done(Rx_Done),
    .Rx_Active(Rx_Active),
    .Framing_Error(Framing_Error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit         ferr;
    logic [7:0] data;
    int         due;
  } exp_t;

  int         btab [8] = '{1042, 695, 521, 261, 174, 87, 79, 39};
  exp_t       expq [$];
  logic [7:0] last_good = 8'h00;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         active_cyc = 0;
  int         done_cyc [$];
  logic [7:0] done_byte [$];
  int         last_t0 = 0;
  bit         prev_done = 1'b0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Every cycle: reset values, event timing/content against the queue, byte hold
  task automatic monitor();
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        check(Rx_Byte == 8'h00, "rst_byte", Rx_Byte, 0);
        check(Rx_Done == 1'b0, "rst_done", Rx_Done, 0);
        check(Rx_Active == 1'b0, "rst_active", Rx_Active, 0);
        check(Framing_Error == 1'b0, "rst_ferr", Framing_Error, 0);
        last_good = 8'h00;
        prev_done = 1'b0;
      end else begin
        check(!(Rx_Done && Framing_Error), "done_and_ferr", Rx_Done, 0);
        if (prev_done) check(Rx_Active == 1'b0, "active_after_done", Rx_Active, 0);
        if (Rx_Done) begin
          done_cnt++;
          done_cyc.push_back(cyc);
          done_byte.push_back(Rx_Byte);
          check(!prev_done, "done_width", 2, 1);
          check(Rx_Active == 1'b1, "active_at_done", Rx_Active, 1);
          if (expq.size() == 0 || expq[0].ferr) begin
            check(1'b0, "unexpected_done", Rx_Byte, -1);
            last_good = Rx_Byte;  // resync after a reported error
          end else begin
            check(cyc >= expq[0].due - 1 && cyc <= expq[0].due + 1, "done_time", cyc, expq[0].due);
            check(Rx_Byte == expq[0].data, "done_byte", Rx_Byte, expq[0].data);
            last_good = expq[0].data;
            void'(expq.pop_front());
          end
        end else if (Framing_Error) begin
          ferr_cnt++;
          check(Rx_Active == 1'b1, "active_at_ferr", Rx_Active, 1);
          if (expq.size() == 0 || !expq[0].ferr) begin
            check(1'b0, "unexpected_ferr", cyc, -1);
            if (expq.size() > 0) void'(expq.pop_front());
          end else begin
            check(cyc >= expq[0].due - 1 && cyc <= expq[0].due + 1, "ferr_time", cyc, expq[0].due);
            void'(expq.pop_front());
          end
        end else if (expq.size() > 0 && cyc > expq[0].due + 1) begin
          check(1'b0, expq[0].ferr ? "missed_ferr" : "missed_done", cyc, expq[0].due);
          void'(expq.pop_front());
        end
        check(Rx_Byte == last_good, "byte_hold", Rx_Byte, last_good);
        if (Rx_Active) active_cyc++;
        prev_done = Rx_Done;
      end
    end
  endtask

  // Called at a negedge; leaves the line high at a negedge when it returns
  task automatic send_frame(input logic [7:0] data, input bit stop, input int extra_low,
                            input int switch_sel, input bit expect_it);
    int b;
    b = btab[baud_rate_select];
    last_t0 = cyc;
    if (expect_it) expq.push_back(exp_t'{!stop, data, cyc + 3 + b / 2 + 9 * b});
    Rx_Serial = 1'b0;
    repeat (b) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      if (i == 2 && switch_sel >= 0) baud_rate_select = 3'(switch_sel);
      Rx_Serial = data[i];
      repeat (b) @(negedge clock);
    end
    Rx_Serial = stop;
    repeat (b + (stop ? 0 : extra_low)) @(negedge clock);
    Rx_Serial = 1'b1;
  endtask

  task automatic idle(input int n);
    Rx_Serial = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  function automatic int last_done_byte();
    return (done_byte.size() > 0) ? int'(done_byte[done_byte.size() - 1]) : -1;
  endfunction

  initial begin
    int d0, f0, n;
    logic [7:0] data;
    bit stop;
    fork
      monitor();
    join_none

    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    idle(3);

    // Single byte at sel 5, latency pinned by hand: 2+1+43+783
    baud_rate_select = 3'd5;
    idle(4);
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, 0, -1, 1'b1);
    idle(20);
    check(done_cnt - d0 == 1, "a5_done_count", done_cnt - d0, 1);
    check(ferr_cnt == f0, "a5_no_ferr", ferr_cnt - f0, 0);
    check(last_done_byte() == 8'hA5, "a5_byte", last_done_byte(), 8'hA5);
    if (done_cyc.size() > 0)
      check(done_cyc[done_cyc.size() - 1] - last_t0 >= 828 && done_cyc[done_cyc.size() - 1] - last_t0 <= 830,
            "a5_latency", done_cyc[done_cyc.size() - 1] - last_t0, 829);

    // Glitch at sel 7: active for exactly H=19 cycles, nothing else
    baud_rate_select = 3'd7;
    idle(4);
    d0 = done_cnt; f0 = ferr_cnt; active_cyc = 0;
    Rx_Serial = 1'b0;
    repeat (10) @(negedge clock);
    idle(40);
    check(active_cyc == 19, "glitch_active_len", active_cyc, 19);
    check(done_cnt == d0 && ferr_cnt == f0, "glitch_no_events", done_cnt - d0 + ferr_cnt - f0, 0);
    check(Rx_Byte == 8'hA5, "glitch_byte", Rx_Byte, 8'hA5);

    // Framing error at sel 7, line held low 100 more cycles
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 100, -1, 1'b1);
    @(posedge clock); #1;
    check(Rx_Active == 1'b1, "ferr_active_held", Rx_Active, 1);
    repeat (5) @(posedge clock);
    #1;
    check(Rx_Active == 1'b0, "ferr_active_release", Rx_Active, 0);
    @(negedge clock);
    check(ferr_cnt - f0 == 1, "ferr_count", ferr_cnt - f0, 1);
    check(done_cnt == d0, "ferr_no_done", done_cnt - d0, 0);
    check(Rx_Byte == 8'hA5, "ferr_byte_kept", Rx_Byte, 8'hA5);

    // Back-to-back 00, FF at sel 7: spacing 10*39
    idle(4);
    n = done_cyc.size();
    send_frame(8'h00, 1'b1, 0, -1, 1'b1);
    send_frame(8'hFF, 1'b1, 0, -1, 1'b1);
    idle(30);
    check(done_cyc.size() - n == 2, "b2b_count", done_cyc.size() - n, 2);
    if (done_cyc.size() - n == 2) begin
      check(done_byte[n] == 8'h00, "b2b_byte0", done_byte[n], 8'h00);
      check(done_byte[n + 1] == 8'hFF, "b2b_byte1", done_byte[n + 1], 8'hFF);
      check(done_cyc[n + 1] - done_cyc[n] >= 389 && done_cyc[n + 1] - done_cyc[n] <= 391,
            "b2b_spacing", done_cyc[n + 1] - done_cyc[n], 390);
    end

    // Reset during data bit 3 at sel 4; bits 3..7 and stop are high so no restart
    baud_rate_select = 3'd4;
    idle(4);
    d0 = done_cnt;
    fork
      send_frame(8'hFA, 1'b1, 0, -1, 1'b0);
      begin
        repeat (4 * 174 + 87) @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check(Rx_Byte == 8'h00 && Rx_Active == 1'b0, "midframe_reset", Rx_Byte, 0);
        @(negedge clock);
        reset = 1'b1;
      end
    join
    idle(10);
    check(done_cnt == d0, "reset_no_done", done_cnt - d0, 0);
    send_frame(8'h5A, 1'b1, 0, -1, 1'b1);
    idle(20);
    check(last_done_byte() == 8'h5A, "after_reset_byte", last_done_byte(), 8'h5A);

    // Select moves 6 -> 0 during bit 2; frame still decoded at 79 clocks per bit
    baud_rate_select = 3'd6;
    idle(4);
    send_frame(8'hC3, 1'b1, 0, 0, 1'b1);
    idle(20);
    check(last_done_byte() == 8'hC3, "selchg_byte", last_done_byte(), 8'hC3);

    // Randomized frames, gaps and framing errors
    for (int k = 0; k < 16; k++) begin
      data = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      baud_rate_select = 3'($urandom_range(3, 7));
      send_frame(data, stop, stop ? 0 : int'($urandom_range(0, 30)), -1, 1'b1);
      idle(stop ? int'($urandom_range(0, 20)) : int'($urandom_range(2, 20)));
    end

    for (int w = 0; w < 3000 && expq.size() > 0; w++) @(negedge clock);
    check(expq.size() == 0, "drain", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
